// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 cracking datapath.
package md5_pkg;

  // Plaintext word geometry.
  localparam int PT_WIDTH = 128;
  localparam int PT_BYTES = PT_WIDTH / 8;

  // Width of the byte counter inside the plaintext unloader.
  localparam int PT_CNT_W = $clog2(PT_BYTES);

  // Unloader control states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pt_unload_state_e;

endpackage

// File: rtl/pt_unload.sv
// Plaintext unloader: captures a plaintext word on a load strobe and streams
// it out most-significant byte first over a valid/ready byte interface.
// All outputs come straight from flops, so there is no path from en or
// out_ready to any output.
module pt_unload
  import md5_pkg::*;
#(
  parameter int WIDTH = PT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic             busy,
  output logic [7:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  localparam int BYTES = WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  pt_unload_state_e state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic handshake;
  logic last_byte;

  assign handshake = (state_q == SEND) && out_ready;
  assign last_byte = (cnt_q == LAST_IDX);

  // State, shift register, counter and done pulse; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state: load in IDLE, return to IDLE on the final byte handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = SEND;
      SEND: if (handshake && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on load, shift out one byte per handshake, flag completion.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          shift_d = in;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (handshake) begin
          shift_d = {shift_q[WIDTH-9:0], 8'h00};
          if (last_byte) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  // Outputs decoded from registered state only; out is forced to zero when idle.
  always_comb begin
    busy      = (state_q == SEND);
    out_valid = (state_q == SEND);
    out       = (state_q == SEND) ? shift_q[WIDTH-1 -: 8] : 8'h00;
    done      = done_q;
  end

endmodule

// File: tb/tb_pt_unload.sv
// Directed self-checking bench for the plaintext unloader.
module tb_pt_unload;

  logic         clk;
  logic         rst;
  logic [127:0] in;
  logic         en;
  logic         busy;
  logic [7:0]   out;
  logic         out_valid;
  logic         out_ready;
  logic         done;

  int checks;
  int errors;

  localparam logic [127:0] WORD_A  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] WORD_A5 = {16{8'hA5}};
  localparam logic [127:0] WORD_0F = {16{8'h0F}};

  pt_unload dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .en        (en),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte i of a word, most significant byte first.
  function automatic logic [7:0] byteOf(input logic [127:0] word, input int i);
    return word[127 - 8*i -: 8];
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [127:0] w, input logic rdy);
    en        = e;
    in        = w;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"},      busy,      0);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out"},       out,       0);
  endtask

  task automatic checkByte(input string tag, input logic [7:0] b);
    checkOutput({tag, " out_valid"}, out_valid, 1);
    checkOutput({tag, " busy"},      busy,      1);
    checkOutput({tag, " out"},       out,       b);
    checkOutput({tag, " done"},      done,      0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkIdle("reset");
    checkOutput("reset done", done, 0);

    // Streaming with out_ready held high; ready while idle is ignored
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkIdle("idle ready");
    applyStimulus(1'b1, WORD_A, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkByte($sformatf("stream b%0d", i), byteOf(WORD_A, i));
      tick();
    end
    checkOutput("stream done", done, 1);
    checkIdle("stream end");
    tick();
    checkOutput("stream done gone", done, 0);
    checkIdle("stream after");

    // Alternating ready with a stall per byte; ignored load of A5 at byte 7
    applyStimulus(1'b1, WORD_A, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) applyStimulus(1'b1, WORD_A5, 1'b0);
      checkByte($sformatf("stall b%0d", i), byteOf(WORD_A, i));
      tick();
      applyStimulus(1'b0, '0, 1'b1);
      checkByte($sformatf("held b%0d", i), byteOf(WORD_A, i));
      tick();
      applyStimulus(1'b0, '0, 1'b0);
    end
    checkOutput("toggle done", done, 1);
    checkIdle("toggle end");

    // Load in the done cycle starts the next transfer immediately
    applyStimulus(1'b1, WORD_0F, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("back2back done gone", done, 0);
    for (int i = 0; i < 9; i++) begin
      checkByte($sformatf("second b%0d", i), byteOf(WORD_0F, i));
      tick();
    end

    // Reset during byte 9 with a stall discards the word
    applyStimulus(1'b0, '0, 1'b0);
    checkByte("pre-reset b9", byteOf(WORD_0F, 9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("mid reset");
    checkOutput("mid reset done", done, 0);
    tick();
    checkIdle("post reset");
    checkOutput("post reset done", done, 0);

    // Long stall after load holds byte 0, then the full word streams from byte 0
    applyStimulus(1'b1, WORD_A, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      checkByte($sformatf("long stall c%0d", i), byteOf(WORD_A, 0));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkByte($sformatf("resume b%0d", i), byteOf(WORD_A, i));
      tick();
    end
    checkOutput("resume done", done, 1);
    checkIdle("resume end");
    tick();
    checkOutput("resume done gone", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
